// File: rtl/uart_pkg.sv
// Shared encodings and clamp limits for the parametrised UART receiver.
package uart_pkg;

  localparam int unsigned MIN_DIV  = 4;
  localparam int unsigned MIN_BITS = 5;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Encodings 0 and 3 both mean "no parity bit on the wire".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a write while full is accepted only if a read retires the head.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic [AW:0]      count_n;

  assign rd_ok_c   = rd_en && !empty;
  assign wr_ok_c   = wr_en && (!full || rd_ok_c);
  assign count_n   = count + (AW+1)'(wr_ok_c) - (AW+1)'(rd_ok_c);
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage needs no reset: the head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, majority-voting bit sampler, framing FSM
// and an error-tagged receive FIFO with ready/valid output.
module uart_rx_param import uart_pkg::*; #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ser,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [3:0]        data_bits,
  input  logic [1:0]        parity_mode,
  input  logic [1:0]        stop_bits,
  input  logic              bit_order,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              busy
);

  localparam int unsigned WORD_W = DATA_W + 2;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rx_state_e          state_q, state_n;
  logic               s_meta, s;
  logic [DIV_W-1:0]   cnt_q, cnt_n;
  logic [3:0]         idx_q, idx_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic               perr_q, perr_n, ferr_q, ferr_n;
  logic               armed_q, armed_n;
  logic               smp0_q, smp0_n, smp1_q, smp1_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [3:0]         nb_q, nb_n;
  logic [1:0]         pm_q, pm_n, sb_q, sb_n;
  logic               ord_q, ord_n;

  logic [DIV_W-1:0]   half_c, bit_end_c, div_in_c;
  logic [3:0]         nb_in_c, pos_c;
  logic [1:0]         sb_in_c;
  logic               at_end_c, at_dec_c, maj_c, push_c, pop_c;
  logic [WORD_W-1:0]  push_word_c, head_c;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Two-flop synchroniser, idle-high reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= rx_ser;
      s      <= s_meta;
    end
  end

  assign div_in_c  = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
  assign nb_in_c   = (data_bits < 4'(MIN_BITS)) ? 4'(MIN_BITS) :
                     (data_bits > 4'(DATA_W))   ? 4'(DATA_W)   : data_bits;
  assign sb_in_c   = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
  assign half_c    = div_q >> 1;
  assign bit_end_c = div_q - DIV_W'(1);
  assign at_end_c  = (cnt_q == bit_end_c);
  assign at_dec_c  = (cnt_q == half_c + DIV_W'(1));
  assign maj_c     = (smp0_q & smp1_q) | (smp0_q & s) | (smp1_q & s);
  assign pos_c     = ord_q ? (nb_q - 4'd1 - idx_q) : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      smp0_q  <= 1'b1;
      smp1_q  <= 1'b1;
      div_q   <= DIV_W'(MIN_DIV);
      nb_q    <= 4'(MIN_BITS);
      pm_q    <= PAR_NONE;
      sb_q    <= 2'd1;
      ord_q   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
      armed_q <= armed_n;
      smp0_q  <= smp0_n;
      smp1_q  <= smp1_n;
      div_q   <= div_n;
      nb_q    <= nb_n;
      pm_q    <= pm_n;
      sb_q    <= sb_n;
      ord_q   <= ord_n;
      busy    <= (state_n != ST_IDLE);
    end
  end

  // Next-state, bit timing and frame assembly.
  always_comb begin
    state_n = state_q;
    cnt_n   = at_end_c ? '0 : cnt_q + DIV_W'(1);
    idx_n   = idx_q;
    data_n  = data_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    armed_n = armed_q | s;
    smp0_n  = (cnt_q == half_c - DIV_W'(1)) ? s : smp0_q;
    smp1_n  = (cnt_q == half_c) ? s : smp1_q;
    div_n   = div_q;
    nb_n    = nb_q;
    pm_n    = pm_q;
    sb_n    = sb_q;
    ord_n   = ord_q;
    push_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        if (armed_q && !s) begin
          state_n = ST_START;
          div_n   = div_in_c;
          nb_n    = nb_in_c;
          pm_n    = parity_mode;
          sb_n    = sb_in_c;
          ord_n   = bit_order;
          idx_n   = '0;
          data_n  = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (at_dec_c && maj_c) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (at_end_c) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (at_dec_c) begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (pos_c == 4'(i)) data_n[i] = maj_c;
          end
        end
        if (at_end_c) begin
          if (idx_q == nb_q - 4'd1) begin
            state_n = parity_enabled(pm_q) ? ST_PARITY : ST_STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (at_dec_c) perr_n = maj_c ^ (^data_q) ^ (pm_q == PAR_ODD);
        if (at_end_c) begin
          state_n = ST_STOP;
          idx_n   = '0;
        end
      end
      ST_STOP: begin
        if (at_dec_c) ferr_n = ferr_q | ~maj_c;
        // The final stop bit completes at its decision point to regain half a bit of slack.
        if (at_dec_c && (idx_q == 4'(sb_q) - 4'd1)) begin
          push_c  = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
          if (ferr_q | ~maj_c) armed_n = 1'b0;
        end else if (at_end_c) begin
          idx_n = idx_q + 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign push_word_c = {ferr_n, perr_q, data_q};
  assign pop_c       = rx_valid && rx_ready;

  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push_c),
    .wr_data   (push_word_c),
    .rd_en     (pop_c),
    .rd_data_c (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = rx_valid ? head_c[DATA_W-1:0] : '0;
  assign rx_parity_err = rx_valid & head_c[DATA_W];
  assign rx_frame_err  = rx_valid & head_c[DATA_W+1];

  // Sticky overrun: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (push_c && fifo_full && !pop_c) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  fifo_count_consistent: assert property (@(posedge clk) disable iff (rst)
    (fifo_count <= CNT_W'(FIFO_DEPTH)) && (rx_valid == (fifo_count != '0)));

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: frame-level reference model, per-cycle head compare, directed and random frames.
module tb_uart_rx_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_ser;
  logic [DIV_W-1:0]  divisor;
  logic [3:0]        data_bits;
  logic [1:0]        parity_mode;
  logic [1:0]        stop_bits;
  logic              bit_order;
  logic [DATA_W-1:0] rx_data;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              overrun_clr;
  logic              busy;

  int          checks = 0;
  int          errors = 0;
  int          n_popped = 0;
  bit          exp_ovr = 1'b0;
  bit          rand_ready = 1'b0;
  logic [9:0]  exp_q [$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_W     (DATA_W),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_ser        (rx_ser),
    .divisor       (divisor),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .bit_order     (bit_order),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .busy          (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Head of the DUT FIFO must always equal the oldest word the model expects.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h expected=none",
                 {rx_frame_err, rx_parity_err, rx_data});
      end else begin
        chk("head_word", 32'({rx_frame_err, rx_parity_err, rx_data}), 32'(exp_q[0]));
        if (rx_ready) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  end

  // Drives one frame and records what the receiver must deliver for it.
  task automatic send_frame(input logic [7:0] d, input int nb_raw, input int pm, input int sb_raw,
                            input bit ord, input int div_raw, input bit bad_par,
                            input logic [2:0] stop_low, input bit scramble);
    int div, nb, sb, cyc;
    bit pen, p, fe, pe;
    logic [7:0] dm;
    logic [2:0] sbmask;
    logic bits [$];
    div = (div_raw < 4) ? 4 : div_raw;
    nb  = (nb_raw < 5) ? 5 : ((nb_raw > 8) ? 8 : nb_raw);
    sb  = (sb_raw == 0) ? 1 : sb_raw;
    pen = (pm == 1) || (pm == 2);
    dm  = d & 8'((1 << nb) - 1);
    divisor     = DIV_W'(div_raw);
    data_bits   = 4'(nb_raw);
    parity_mode = 2'(pm);
    stop_bits   = 2'(sb_raw);
    bit_order   = ord;
    bits.push_back(1'b0);
    for (int k = 0; k < nb; k++) bits.push_back(ord ? dm[nb-1-k] : dm[k]);
    p = ^dm;
    if (pm == 2) p = ~p;
    if (pen) bits.push_back(p ^ bad_par);
    for (int i = 0; i < sb; i++) bits.push_back(~stop_low[i]);
    sbmask = 3'((1 << sb) - 1);
    fe = |(stop_low & sbmask);
    pe = pen & bad_par;
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back({fe, pe, dm});
    cyc = 0;
    foreach (bits[i]) begin
      for (int c = 0; c < div; c++) begin
        rx_ser = bits[i];
        tick();
        cyc++;
        if (scramble && cyc == 8) begin
          divisor     = DIV_W'($urandom);
          data_bits   = 4'($urandom);
          parity_mode = 2'($urandom);
          stop_bits   = 2'($urandom);
          bit_order   = 1'($urandom);
        end
      end
    end
    rx_ser = 1'b1;
  endtask

  task automatic check_head(input string name, input logic [9:0] exp);
    int n;
    n = 0;
    while (!rx_valid && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    chk(name, 32'({rx_frame_err, rx_parity_err, rx_data}), 32'(exp));
  endtask

  task automatic pop_one;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n, p0;
    logic [7:0] partial;
    rst = 1'b1; rx_ser = 1'b1; rx_ready = 1'b0; overrun_clr = 1'b0;
    divisor = 16; data_bits = 8; parity_mode = 0; stop_bits = 1; bit_order = 0;
    repeat (3) tick();
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_errs", 32'({rx_frame_err, rx_parity_err}), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (5) tick();

    // 8N1 LSB first, 0xA5, with start-edge-to-valid latency
    fork
      send_frame(8'hA5, 8, 0, 1, 1'b0, 16, 1'b0, 3'b000, 1'b0);
      begin
        n = 0;
        while (!rx_valid && n < 400) begin
          tick();
          n++;
        end
        chk("latency_8n1", 32'(n), 32'd157);
      end
    join
    check_head("word_a5", {2'b00, 8'hA5});
    chk("a5_overrun", 32'(overrun), 0);
    pop_one();

    // 7 bits, MSB first, even parity inverted then odd parity correct
    send_frame(8'h55, 7, 1, 1, 1'b1, 16, 1'b1, 3'b000, 1'b0);
    check_head("even_bad_parity", {2'b01, 8'h55});
    pop_one();
    send_frame(8'h55, 7, 2, 1, 1'b1, 16, 1'b0, 3'b000, 1'b0);
    check_head("odd_good_parity", {2'b00, 8'h55});
    pop_one();

    // 3-cycle low glitch must be rejected as a false start
    divisor = 16; data_bits = 8; parity_mode = 0; stop_bits = 1; bit_order = 0;
    rx_ser = 1'b0;
    repeat (3) tick();
    rx_ser = 1'b1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("glitch_busy_seen", 32'(busy), 1);
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("glitch_busy_clear", 32'(busy), 0);
    chk("glitch_no_word", 32'(rx_valid), 0);

    // Second stop bit low, then break: exactly one word with frame error
    p0 = n_popped;
    send_frame(8'hC3, 8, 0, 2, 1'b0, 16, 1'b0, 3'b010, 1'b0);
    rx_ser = 1'b0;
    repeat (50 * 16) tick();
    chk("break_idle", 32'(busy), 0);
    rx_ser = 1'b1;
    repeat (40) tick();
    check_head("break_word", {2'b10, 8'hC3});
    rx_ready = 1'b1;
    repeat (5) tick();
    rx_ready = 1'b0;
    chk("break_one_word", 32'(n_popped - p0), 1);
    chk("break_drained", 32'(rx_valid), 0);

    // Fill a 4-deep FIFO with 5 frames while not popping
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 8, 0, 1, 1'b0, 16, 1'b0, 3'b000, 1'b0);
    repeat (6) tick();
    chk("overrun_set", 32'(overrun), 32'(exp_ovr));
    chk("overrun_set_lit", 32'(overrun), 1);
    for (int v = 1; v <= 4; v++) begin
      check_head("fifo_order", {2'b00, 8'(v)});
      pop_one();
    end
    tick();
    chk("fifo_fifth_dropped", 32'(rx_valid), 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 0);

    // Reset in the middle of data bit 3 with a word still queued
    send_frame(8'h11, 8, 0, 1, 1'b0, 16, 1'b0, 3'b000, 1'b0);
    repeat (4) tick();
    partial = 8'h77;
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < ((b == 4) ? 8 : 16); c++) begin
        rx_ser = (b == 0) ? 1'b0 : partial[b-1];
        tick();
      end
    end
    rst = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_valid", 32'(rx_valid), 0);
    chk("midreset_data", 32'(rx_data), 0);
    chk("midreset_overrun", 32'(overrun), 0);
    rx_ser = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h3C, 8, 0, 1, 1'b0, 16, 1'b0, 3'b000, 1'b0);
    check_head("after_reset", {2'b00, 8'h3C});
    pop_one();

    // Randomised frames, random backpressure, config changed mid-frame
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), $urandom_range(0, 12), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, 1'b1);
      repeat ($urandom_range(4, 10)) tick();
    end
    rand_ready = 1'b0;
    tick();
    rx_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
    chk("random_drained", 32'(exp_q.size()), 0);
    repeat (3) tick();
    chk("random_no_extra", 32'(rx_valid), 0);
    chk("random_overrun", 32'(overrun), 32'(exp_ovr));
    rx_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
